f16_convert_seq: RTL

Sequencer that streams a block of packed half-precision words from a source BRAM through the f16→f32 conversion datapath and writes the single-precision results to a destination BRAM. It sits between the host-loaded input buffer and the compute engine's float32 operand memory. It replaces the software per-word conversion loop with a one-word-per-cycle pipelined hardware pass, bit-exact with the software conversion.

---
 rtl/f16_pkg.sv | 18 +
 rtl/f16_to_f32.sv | 19 +
 rtl/f16_convert_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/f16_pkg.sv
// Shared types and constants for the half -> single conversion sequencer.
package f16_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } f16_t;

  localparam logic [7:0] F16_TO_F32_EXP_ADJ = 8'd112;

  // The half arrives byte-swapped in the upper 16 bits of the source word.
  localparam int HALF_LO_LSB = 24;
  localparam int HALF_HI_LSB = 16;

endpackage

// File: rtl/f16_to_f32.sv
// Combinational f16 -> f32 re-bias; deliberately no special-casing so results
// match the legacy software conversion bit for bit.
module f16_to_f32
  import f16_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  f16_t       half;
  logic [7:0] exp32;
  logic       unused_lo;

  assign half      = {din[HALF_HI_LSB +: 8], din[HALF_LO_LSB +: 8]};
  assign exp32     = {3'b000, half.exp} + F16_TO_F32_EXP_ADJ;
  assign dout      = {half.sign, exp32, half.man, 13'b0};
  assign unused_lo = ^din[15:0];

endmodule

// File: rtl/f16_convert_seq.sv
// Streams len words src BRAM -> f16_to_f32 -> dst BRAM at one word per cycle.
module f16_convert_seq
  import f16_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [31:0]       src_rdata,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [31:0]       dst_wdata
);

  // Stage 0 = read issued, 1 = BRAM data valid, 2 = write issued.
  localparam int STAGES = 2;

  state_t            state;
  logic [ADDR_W-1:0] src_base_q, dst_base_q;
  logic [LEN_W-1:0]  len_q, rd_cnt, wr_cnt;
  logic [STAGES:0]   vld_pipe;
  logic [31:0]       conv;

  f16_to_f32 u_conv (.din(src_rdata), .dout(conv));

  assign src_en = vld_pipe[0];
  assign dst_we = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      vld_pipe   <= '0;
      src_addr   <= '0;
      dst_addr   <= '0;
      dst_wdata  <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
      done     <= 1'b0;

      if (vld_pipe[1]) begin
        dst_wdata <= conv;
        dst_addr  <= dst_base_q + ADDR_W'(wr_cnt);
        wr_cnt    <= wr_cnt + LEN_W'(1);
      end

      case (state)
        IDLE: if (start) begin
          src_base_q <= src_base;
          dst_base_q <= dst_base;
          len_q      <= len;
          wr_cnt     <= '0;
          if (len == '0) begin
            rd_cnt <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            // First read goes out with the state change so read k lands in cycle 1+k.
            busy        <= 1'b1;
            vld_pipe[0] <= 1'b1;
            src_addr    <= src_base;
            rd_cnt      <= LEN_W'(1);
            state       <= (len == LEN_W'(1)) ? DRAIN : RUN;
          end
        end
        RUN: begin
          vld_pipe[0] <= 1'b1;
          src_addr    <= src_base_q + ADDR_W'(rd_cnt);
          rd_cnt      <= rd_cnt + LEN_W'(1);
          if (rd_cnt == len_q - LEN_W'(1)) state <= DRAIN;
        end
        DRAIN: if (wr_cnt == len_q) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
